if_prefetch_ctrl: RTL and testbench
===================================

Name: if_prefetch_ctrl

Overview:
- Instruction prefetch engine: the producer/writer end of the instruction-fetch buffer. It issues sequential word reads to instruction memory and pushes returned instructions, tagged with their PC, into a downstream sync FIFO of depth FIFO_DEPTH.
- Uses credit-based flow control, so a push is never refused.
- Handles branch redirects by flushing the downstream buffer and discarding in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory reads.
- FIFO_DEPTH, 8, entry count of the downstream buffer; initial credit.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid; in order, never earlier than cycle after accept, no backpressure.
- imem_rsp_data  in  XLEN  instruction word.
- pf_push  out  1  push strobe into downstream buffer.
- pf_push_data  out  2*XLEN  {pc, instr}.
- pf_pop  in  1  downstream consumer handshake (buffer tx_valid && tx_ready); returns one credit.
- pf_flush  out  1  one-cycle pulse; downstream buffer empties this cycle.
- redirect_valid  in  1  branch/exception redirect.
- redirect_pc  in  XLEN  new fetch PC.
- pf_stall  in  1  suppress new requests; in-flight responses still complete.

Behaviour:
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, pf_push=0, pf_push_data=0, pf_flush=0. Internal state: state=S_BOOT, fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, occupancy=0, drop_cnt=0.
- FSM S_BOOT: exactly one cycle after reset release, then S_RUN.
- FSM S_RUN: issues requests.
  - redirect_valid with outstanding (after this cycle's response) > 0: go to S_DRAIN.
  - Otherwise remain in S_RUN.
- FSM S_DRAIN: no requests issued.
  - Go to S_RUN in the cycle after drop_cnt reaches 0.
  - A redirect arriving in S_DRAIN updates fetch_pc; drop_cnt keeps counting.
- Issue rule: imem_req_valid = (state==S_RUN) && !pf_stall && !redirect_valid && outstanding<MAX_OUTSTANDING && (outstanding+occupancy)<FIFO_DEPTH. Combinational.
- imem_req_addr = fetch_pc.
- Accept (valid && ready): fetch_pc += 4 (wraps mod 2^XLEN); outstanding += 1.
- Response when drop_cnt==0 and no redirect this cycle:
  - pf_push=1 in the same cycle (combinational pass-through).
  - pf_push_data={rsp_pc, imem_rsp_data}.
  - rsp_pc += 4; outstanding -= 1; occupancy += 1.
- Response when drop_cnt>0: discarded, no push, drop_cnt -= 1, outstanding -= 1.
- pf_pop: occupancy -= 1. Push and pop in the same cycle leave occupancy unchanged.
- Redirect cycle:
  - pf_flush=1; no push; occupancy <= 0 (any pop that cycle is ignored).
  - fetch_pc <= rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt <= outstanding minus 1 if a response arrives this cycle (that response is itself dropped).
  - Request suppressed; memory tolerates withdrawal of an unaccepted request.
- Credit invariant: outstanding+occupancy <= FIFO_DEPTH at all times, so downstream rx_ready is never low when pf_push=1.
- Bench assertions:
  - Violation of the credit invariant.
  - imem_rsp_valid with outstanding==0.
- Counter widths: outstanding is $clog2(MAX_OUTSTANDING+1) bits; occupancy is $clog2(FIFO_DEPTH+1) bits; drop_cnt matches outstanding.
- Reset mid-operation: all state returns to reset values asynchronously. The memory subsystem is reset concurrently, so stale responses cannot arrive.

Decomposition:
- Shared package: FSM state encodings S_BOOT/S_RUN/S_DRAIN, the INSTR_BYTES=4 constant, and the RESET_PC default.
- One natural sub-module: pf_credit_ctr, holding the outstanding/occupancy/drop counters and the issue-permit output.
- FSM and PC logic live in the top module.

Test Plan:
- Reset release, memory ready=1, 1-cycle response latency, pf_pop held 1 -> requests at 0x0,0x4,0x8…; pushes {0x0,i0},{0x4,i1}… in order; outstanding never exceeds 2.
- pf_pop held 0 with zero-latency-accepting memory -> exactly 8 pushes (PCs 0x0–0x1C), then imem_req_valid stays 0; one pf_pop -> exactly one more request, to 0x20.
- Two requests outstanding, redirect_valid with redirect_pc=0x1003 -> pf_flush pulse; both responses dropped (no push); state returns to S_RUN; next request addr 0x1000, first push pc 0x1000.
- Redirect in the same cycle as a response with one other outstanding -> that response dropped, drop_cnt=1, the following response also dropped, no pushes until the new stream.
- pf_stall=1 for 5 cycles with 2 outstanding -> both responses pushed, no new requests; stall release -> fetch resumes at the next sequential PC.
- fetch_pc=0xFFFF_FFFC accepted -> next request addr 0x0000_0000; asynchronous reset asserted mid-stream -> all outputs at reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_ctrl_pkg
// Brief    : Shared constants and FSM encodings for the instruction prefetcher.
// Revision : 1.0
// ============================================================================
package if_prefetch_ctrl_pkg;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [1:0] state_t;
   localparam state_t S_BOOT  = 2'd0;
   localparam state_t S_RUN   = 2'd1;
   localparam state_t S_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_ctrl_if
// Brief    : Memory, push-buffer and redirect signals of the prefetcher.
// Revision : 1.0
// ============================================================================
interface if_prefetch_ctrl_if #(
   parameter int XLEN = 32
) ();
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_rsp_valid;
   logic [XLEN-1:0]   imem_rsp_data;
   logic              pf_push;
   logic [2*XLEN-1:0] pf_push_data;
   logic              pf_pop;
   logic              pf_flush;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              pf_stall;

   modport master (
      output imem_req_valid, imem_req_addr, pf_push, pf_push_data, pf_flush,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, pf_pop,
             redirect_valid, redirect_pc, pf_stall
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, pf_push, pf_push_data, pf_flush,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, pf_pop,
             redirect_valid, redirect_pc, pf_stall
   );
endinterface
`default_nettype wire

// File: rtl/if_prefetch_ctrl_pf_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module   : pf_credit_ctr
// Brief    : Outstanding/occupancy/drop counters and request issue permit.
// Revision : 1.0
// ============================================================================
module pf_credit_ctr #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIFO_DEPTH      = 8,
   parameter int OW              = $clog2(MAX_OUTSTANDING + 1),
   parameter int CW              = $clog2(FIFO_DEPTH + 1)
) (
   input  wire logic clk,
   input  wire logic rstn,
   input  wire logic accept_i,
   input  wire logic rsp_valid_i,
   input  wire logic redirect_i,
   input  wire logic pop_i,
   output logic      issue_ok_o,
   output logic      push_o,
   output logic      drop_zero_next_o
);
   localparam int SW = ((OW > CW) ? OW : CW) + 1;

   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] drop_cnt_q,    drop_cnt_d;
   logic [CW-1:0] occupancy_q,   occupancy_d;
   logic [SW-1:0] w_credit_used;

   always_comb begin
      w_credit_used = SW'(outstanding_q) + SW'(occupancy_q);
      issue_ok_o    = (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                      (w_credit_used < SW'(FIFO_DEPTH));
      push_o        = rsp_valid_i && (drop_cnt_q == '0) && !redirect_i;

      outstanding_d = outstanding_q + OW'(accept_i) - OW'(rsp_valid_i);

      // Every read still in flight at a redirect belongs to the old stream.
      drop_cnt_d = drop_cnt_q;
      if (redirect_i)
         drop_cnt_d = outstanding_d;
      else if (rsp_valid_i && (drop_cnt_q != '0))
         drop_cnt_d = drop_cnt_q - 1'b1;
      drop_zero_next_o = (drop_cnt_d == '0);

      if (redirect_i)
         occupancy_d = '0;
      else
         occupancy_d = occupancy_q + CW'(push_o) - CW'(pop_i);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         occupancy_q   <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         occupancy_q   <= occupancy_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/if_prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_ctrl
// Brief    : Credit-based sequential instruction prefetcher with redirect flush.
// Revision : 1.0
// ============================================================================
module if_prefetch_ctrl
   import if_prefetch_ctrl_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
   parameter int              MAX_OUTSTANDING = 2,
   parameter int              FIFO_DEPTH      = 8
) (
   input wire logic           clk,
   input wire logic           rstn,
   if_prefetch_ctrl_if.master bus
);
   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_issue_ok;
   logic            w_push;
   logic            w_drop_zero_next;
   logic            w_req_valid;
   logic            w_accept;

   assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign w_req_valid   = (state_q == S_RUN) && !bus.pf_stall &&
                          !bus.redirect_valid && w_issue_ok;
   assign w_accept      = w_req_valid && bus.imem_req_ready;

   pf_credit_ctr #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .FIFO_DEPTH      (FIFO_DEPTH)
   ) u_ctr (
      .clk              (clk),
      .rstn             (rstn),
      .accept_i         (w_accept),
      .rsp_valid_i      (bus.imem_rsp_valid),
      .redirect_i       (bus.redirect_valid),
      .pop_i            (bus.pf_pop),
      .issue_ok_o       (w_issue_ok),
      .push_o           (w_push),
      .drop_zero_next_o (w_drop_zero_next)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
      end
   end

   // Drain only while stale reads remain once this cycle's response retires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   if (bus.redirect_valid && !w_drop_zero_next) state_d = S_DRAIN;
         S_DRAIN: if (w_drop_zero_next) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = w_redirect_pc;
         rsp_pc_d   = w_redirect_pc;
      end else begin
         if (w_accept) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
         if (w_push)   rsp_pc_d   = rsp_pc_q + XLEN'(INSTR_BYTES);
      end
   end

   always_comb begin
      bus.imem_req_valid = w_req_valid;
      bus.imem_req_addr  = fetch_pc_q;
      bus.pf_push        = w_push;
      bus.pf_push_data   = w_push ? {rsp_pc_q, bus.imem_rsp_data} : '0;
      bus.pf_flush       = bus.redirect_valid;
   end
endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_ctrl
// Brief    : Randomized self-checking bench with a queue-based fetch model.
// Revision : 1.0
// ============================================================================
module tb_if_prefetch_ctrl;
   import if_prefetch_ctrl_pkg::*;

   localparam int DEPTH = 8;
   localparam int MAXO  = 2;

   logic clk = 1'b0;
   logic rstn;

   if_prefetch_ctrl_if #(.XLEN(32)) bus ();

   if_prefetch_ctrl #(
      .XLEN            (32),
      .RESET_PC        (32'h0),
      .MAX_OUTSTANDING (MAXO),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      bit          live;
   } ent_t;

   ent_t        q[$];
   int          occ;
   logic [31:0] nxt_pc;
   bit          booted;
   int          tests = 0;
   int          fails = 0;
   int          n_push, n_acc;

   int          p_ready, p_rsp, p_stall, p_redir, p_pop;
   bit          fix_pc_en;
   logic [31:0] fix_pc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(99) < p);
   endfunction

   task automatic set_knobs(input int r, input int s, input int st, input int rd, input int pp);
      p_ready = r; p_rsp = s; p_stall = st; p_redir = rd; p_pop = pp;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.pf_pop         = 1'b0;
      #1;
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_req_addr",  64'(bus.imem_req_addr),  64'h0);
      chk("rst_push",      64'(bus.pf_push),        64'd0);
      chk("rst_push_data", bus.pf_push_data,        64'h0);
      chk("rst_flush",     64'(bus.pf_flush),       64'd0);
      q.delete();
      occ    = 0;
      nxt_pc = 32'h0;
      booted = 1'b0;
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
   endtask

   task automatic cycle();
      int          dead;
      bit          rsp, redir, pop, exp_req, exp_push;
      logic [31:0] rpc;
      @(negedge clk);
      rsp   = (q.size() > 0) && pct(p_rsp);
      redir = pct(p_redir);
      pop   = (occ > 0) && pct(p_pop);
      if (fix_pc_en)  rpc = fix_pc;
      else if (pct(20)) rpc = 32'hFFFF_FFF8 | 32'($urandom_range(3));
      else            rpc = $urandom;
      bus.imem_req_ready = pct(p_ready);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? q[0].data : $urandom;
      bus.pf_stall       = pct(p_stall);
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.pf_pop         = pop;
      #1;
      dead = 0;
      foreach (q[i]) if (!q[i].live) dead++;
      exp_req  = booted && (dead == 0) && !bus.pf_stall && !redir &&
                 (q.size() < MAXO) && (q.size() + occ < DEPTH);
      exp_push = rsp && q[0].live && !redir;

      chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
      if (exp_req) chk("req_addr", 64'(bus.imem_req_addr), 64'(nxt_pc));
      chk("push", 64'(bus.pf_push), 64'(exp_push));
      if (exp_push) chk("push_data", bus.pf_push_data, {q[0].pc, q[0].data});
      chk("flush", 64'(bus.pf_flush), 64'(redir));
      chk("credit_inv",
          64'((int'(dut.u_ctr.outstanding_q) + int'(dut.u_ctr.occupancy_q)) <= DEPTH), 64'd1);
      if (rsp) chk("rsp_with_outstanding", 64'(dut.u_ctr.outstanding_q != 0), 64'd1);

      if (bus.pf_push) n_push++;
      if (rsp) begin
         void'(q.pop_front());
         if (exp_push) occ++;
      end
      if (pop && !redir) occ--;
      if (redir) begin
         occ = 0;
         foreach (q[i]) q[i].live = 1'b0;
         nxt_pc = {rpc[31:2], 2'b00};
      end
      if (exp_req && bus.imem_req_ready) begin
         q.push_back('{pc: nxt_pc, data: $urandom, live: 1'b1});
         nxt_pc = nxt_pc + 32'd4;
         n_acc++;
      end
      booted = 1'b1;
   endtask

   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.pf_stall       = 1'b0;
      bus.redirect_pc    = '0;
      fix_pc_en = 1'b0;
      fix_pc    = '0;
      set_knobs(0, 0, 0, 0, 0);
      do_reset();

      // Steady streaming with one-cycle latency and a draining consumer.
      set_knobs(100, 100, 0, 0, 100);
      repeat (30) cycle();

      // Consumer stalled: credit must run out after exactly DEPTH pushes.
      do_reset();
      set_knobs(100, 100, 0, 0, 0);
      n_push = 0;
      repeat (30) cycle();
      chk("pushes_to_full", 64'(n_push), 64'(DEPTH));
      n_acc = 0;
      set_knobs(100, 100, 0, 0, 100);
      cycle();
      set_knobs(100, 100, 0, 0, 0);
      repeat (6) cycle();
      chk("one_credit_one_req", 64'(n_acc), 64'd1);

      // Redirect to 0x1003 with two reads in flight.
      do_reset();
      set_knobs(100, 0, 0, 0, 100);
      repeat (3) cycle();
      fix_pc_en = 1'b1; fix_pc = 32'h0000_1003;
      set_knobs(100, 0, 0, 100, 100);
      cycle();
      fix_pc_en = 1'b0;
      set_knobs(100, 100, 0, 0, 100);
      repeat (12) cycle();

      // Redirect coinciding with a response, near the top of the address space.
      set_knobs(100, 0, 0, 0, 100);
      repeat (3) cycle();
      fix_pc_en = 1'b1; fix_pc = 32'hFFFF_FFF8;
      set_knobs(100, 100, 0, 100, 100);
      cycle();
      fix_pc_en = 1'b0;
      set_knobs(100, 100, 0, 0, 100);
      repeat (12) cycle();

      // Stall with reads in flight, then release.
      set_knobs(100, 0, 0, 0, 100);
      repeat (2) cycle();
      set_knobs(100, 100, 100, 0, 100);
      repeat (5) cycle();
      set_knobs(100, 100, 0, 0, 100);
      repeat (6) cycle();

      // Randomized traffic with periodic asynchronous resets.
      for (int ph = 0; ph < 20; ph++) begin
         set_knobs($urandom_range(20, 100), $urandom_range(20, 100),
                   $urandom_range(0, 30), $urandom_range(0, 12),
                   $urandom_range(0, 100));
         repeat (200) cycle();
         if (ph % 7 == 6) begin
            @(posedge clk);
            #3 do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
